// File: rtl/com_mem_pkg.sv
// Shared types and helpers for the managed single-clock RAM family.
// Also provides the system-config bus width when the platform does not define it.
`ifndef COM_SYS_W
`define COM_SYS_W 8
`endif

package com_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DONE = 2'd2
  } init_state_e;

  localparam int RD_LAT_1 = 1;
  localparam int RD_LAT_2 = 2;

  // Widest data path the lane helper supports.
  localparam int MAX_W = 256;

  function automatic int lane_w(input int data_w, input int strb_w);
    return data_w / strb_w;
  endfunction

  // Bits set in mask take new_d, the rest keep old_d.
  function automatic logic [MAX_W-1:0] merge_lanes(input logic [MAX_W-1:0] mask,
                                                   input logic [MAX_W-1:0] new_d,
                                                   input logic [MAX_W-1:0] old_d);
    return (mask & new_d) | (~mask & old_d);
  endfunction

endpackage

// File: rtl/com_mem_init_fsm.sv
// Init sequencer: sweeps every address once after reset or on request, then flags the RAM usable.
module com_mem_init_fsm
  import com_mem_pkg::*;
#(
  parameter int  DEPTH   = 64,
  parameter bit  INIT_EN = 1'b1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_start_i,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o,
  output logic              init_done_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  init_state_e       state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              we_q;
  logic              done_q;

  // NOTE: state is only ever assigned with <= so every register samples the
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= !INIT_EN;
    end else begin
      case (state_q)
        IDLE: begin
          if (INIT_EN) begin
            state_q <= INIT;
            cnt_q   <= '0;
            we_q    <= 1'b1;
          end else begin
            state_q <= DONE;
          end
        end
        INIT: begin
          done_q <= 1'b0;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            we_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          if (INIT_EN && init_start_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
            we_q    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign init_we_o   = we_q;
  assign init_addr_o = cnt_q;
  assign init_done_o = done_q;

endmodule

// File: rtl/com_tpram1ck_shell.sv
// Single-clock two-port RAM storage: one lane-masked write port, one registered read port.
module com_tpram1ck_shell
  import com_mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int STRB_W   = 1,
  parameter int MEM_USER = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [`COM_SYS_W-1:0] sys_cfg_i,
  input  logic [STRB_W-1:0]     wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_W-1:0]     rd_data_o
);

  localparam int LANE_W = lane_w(DATA_W, STRB_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  // The generic shell has no macro tuning hooks to drive.
  logic unused_cfg;
  assign unused_cfg = ^{sys_cfg_i, 32'(MEM_USER)};

  // NOTE: the array has no reset; contents are defined by the init engine, and a
  // reset on every word would turn the RAM into a flop bank.
  always_ff @(posedge clk) begin
    for (int l = 0; l < STRB_W; l++) begin
      if (wr_en_i[l]) mem_q[wr_addr_i][l*LANE_W +: LANE_W] <= wr_data_i[l*LANE_W +: LANE_W];
    end
    if (rd_en_i) rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/com_tpram1ck_ctrl.sv
// Managed two-port RAM: init engine, 1/2-cycle read latency with valid, per-lane
// same-cycle write forwarding and out-of-range address protection around the shell.
module com_tpram1ck_ctrl
  import com_mem_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 64,
  parameter int              STRB_W    = 1,
  parameter int              MEM_USER  = 0,
  parameter int              RD_LAT    = 1,
  parameter bit              INIT_EN   = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter bit              BYPASS_EN = 1'b1,
  localparam int             ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [`COM_SYS_W-1:0] sys_cfg,
  input  logic                  init_start,
  output logic                  init_done,
  input  logic [STRB_W-1:0]     wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_vld
);

  localparam int              LANE_W  = lane_w(DATA_W, STRB_W);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  if (DATA_W % STRB_W != 0) begin : g_bad_strb
    $error("DATA_W must be a multiple of STRB_W");
  end
  if (RD_LAT != RD_LAT_1 && RD_LAT != RD_LAT_2) begin : g_bad_lat
    $error("RD_LAT must be 1 or 2");
  end
  if (DATA_W > MAX_W) begin : g_bad_width
    $error("DATA_W exceeds the lane helper width");
  end

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              wr_in_rng, rd_in_rng, rd_acc;
  logic [STRB_W-1:0] usr_we, mem_we, fwd_mask_d, fwd_mask_q;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata, fwd_data_q, fwd_bits, rd_mux;
  logic              vld1_q, oor_q;

  com_mem_init_fsm #(.DEPTH(DEPTH), .INIT_EN(INIT_EN)) u_init (
    .clk         (clk),
    .rst         (rst),
    .init_start_i(init_start),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .init_done_o (init_done)
  );

  assign wr_in_rng = {1'b0, wr_addr} < DEPTH_L;
  assign rd_in_rng = {1'b0, rd_addr} < DEPTH_L;

  // User traffic is dropped until the RAM is usable; init sweeps win the write port.
  assign usr_we    = (init_done && wr_in_rng && !init_we) ? wr_en : '0;
  assign rd_acc    = rd_en && init_done;
  assign mem_we    = init_we ? '1 : usr_we;
  assign mem_waddr = init_we ? init_addr : wr_addr;
  assign mem_wdata = init_we ? INIT_VAL : wr_data;

  com_tpram1ck_shell #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .STRB_W(STRB_W), .MEM_USER(MEM_USER)
  ) u_shell (
    .clk      (clk),
    .sys_cfg_i(sys_cfg),
    .wr_en_i  (mem_we),
    .wr_addr_i(mem_waddr),
    .wr_data_i(mem_wdata),
    .rd_en_i  (rd_acc && rd_in_rng),
    .rd_addr_i(rd_addr),
    .rd_data_o(mem_rdata)
  );

  // The shell returns pre-write data on a collision; remember which lanes to patch.
  assign fwd_mask_d = (BYPASS_EN && rd_addr == wr_addr) ? usr_we : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1_q     <= 1'b0;
      oor_q      <= 1'b0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      vld1_q <= rd_acc;
      if (rd_acc) begin
        oor_q      <= !rd_in_rng;
        fwd_mask_q <= fwd_mask_d;
        fwd_data_q <= wr_data;
      end
    end
  end

  for (genvar l = 0; l < STRB_W; l++) begin : g_lane
    assign fwd_bits[l*LANE_W +: LANE_W] = {LANE_W{fwd_mask_q[l]}};
  end

  assign rd_mux = oor_q ? '0
                : DATA_W'(merge_lanes(MAX_W'(fwd_bits), MAX_W'(fwd_data_q), MAX_W'(mem_rdata)));

  if (RD_LAT == RD_LAT_1) begin : g_lat1
    logic [DATA_W-1:0] hold_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         hold_q <= '0;
      else if (vld1_q) hold_q <= rd_mux;
    end
    assign rd_data = vld1_q ? rd_mux : hold_q;
    assign rd_vld  = vld1_q;
  end else begin : g_lat2
    logic [DATA_W-1:0] out_q;
    logic              vld2_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q  <= '0;
        vld2_q <= 1'b0;
      end else begin
        vld2_q <= vld1_q;
        if (vld1_q) out_q <= rd_mux;
      end
    end
    assign rd_data = out_q;
    assign rd_vld  = vld2_q;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && init_done) begin
      assert (!(|wr_en) || wr_in_rng) else $warning("write address %0d beyond DEPTH", wr_addr);
      assert (!rd_en || rd_in_rng) else $warning("read address %0d beyond DEPTH", rd_addr);
    end
  end
`endif

endmodule

// File: tb/tb_com_tpram1ck_ctrl.sv
// Scoreboard bench: instance A (64x32, 4 lanes, RD_LAT=1, bypass) and B (48x32, RD_LAT=2).
module tb_com_tpram1ck_ctrl;
  import com_mem_pkg::*;

  localparam logic [31:0] A_INIT = 32'hA5A5_A5A5;
  localparam logic [31:0] B_INIT = 32'h5A5A_0F0F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic [`COM_SYS_W-1:0] sys_cfg = '0;

  logic        init_start_a, init_done_a, rd_en_a, rd_vld_a;
  logic [3:0]  wr_en_a;
  logic [5:0]  wr_addr_a, rd_addr_a;
  logic [31:0] wr_data_a, rd_data_a;

  logic        init_start_b, init_done_b, rd_en_b, rd_vld_b;
  logic [0:0]  wr_en_b;
  logic [5:0]  wr_addr_b, rd_addr_b;
  logic [31:0] wr_data_b, rd_data_b;

  com_tpram1ck_ctrl #(
    .DATA_W(32), .DEPTH(64), .STRB_W(4), .MEM_USER(0), .RD_LAT(1),
    .INIT_EN(1'b1), .INIT_VAL(A_INIT), .BYPASS_EN(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst_a), .sys_cfg(sys_cfg), .init_start(init_start_a), .init_done(init_done_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_vld(rd_vld_a)
  );

  com_tpram1ck_ctrl #(
    .DATA_W(32), .DEPTH(48), .STRB_W(1), .MEM_USER(0), .RD_LAT(2),
    .INIT_EN(1'b1), .INIT_VAL(B_INIT), .BYPASS_EN(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .sys_cfg(sys_cfg), .init_start(init_start_b), .init_done(init_done_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_vld(rd_vld_b)
  );

  typedef struct { logic [31:0] data; int due; } exp_t;

  exp_t        q_a[$], q_b[$];
  exp_t        e_a, e_b;
  logic [31:0] model_a [64];
  logic [31:0] model_b [48];
  logic [31:0] last_a, last_b;
  int          vld_cnt_a = 0, vld_cnt_b = 0;
  int          checks = 0, errors = 0;
  int          cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Monitors: pop on rd_vld (data and latency), otherwise rd_data must hold.
  always @(negedge clk) begin
    checks++;
    if (rst_a) begin
      last_a = '0;
      if (rd_vld_a !== 1'b0 || rd_data_a !== 32'h0) begin
        errors++;
        $display("FAIL a_reset_out got vld=%b data=%h required vld=0 data=0", rd_vld_a, rd_data_a);
      end
    end else if (rd_vld_a === 1'b1) begin
      vld_cnt_a++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_vld cycle=%0d data=%h required no rd_vld", cyc_n, rd_data_a);
      end else begin
        e_a = q_a.pop_front();
        if (rd_data_a !== e_a.data || cyc_n != e_a.due) begin
          errors++;
          $display("FAIL a_read got data=%h cycle=%0d required data=%h cycle=%0d",
                   rd_data_a, cyc_n, e_a.data, e_a.due);
        end
        last_a = e_a.data;
      end
    end else if (rd_data_a !== last_a) begin
      errors++;
      $display("FAIL a_hold got %h required %h", rd_data_a, last_a);
    end
  end

  always @(negedge clk) begin
    checks++;
    if (rst_b) begin
      last_b = '0;
      if (rd_vld_b !== 1'b0 || rd_data_b !== 32'h0) begin
        errors++;
        $display("FAIL b_reset_out got vld=%b data=%h required vld=0 data=0", rd_vld_b, rd_data_b);
      end
    end else if (rd_vld_b === 1'b1) begin
      vld_cnt_b++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_vld cycle=%0d data=%h required no rd_vld", cyc_n, rd_data_b);
      end else begin
        e_b = q_b.pop_front();
        if (rd_data_b !== e_b.data || cyc_n != e_b.due) begin
          errors++;
          $display("FAIL b_read got data=%h cycle=%0d required data=%h cycle=%0d",
                   rd_data_b, cyc_n, e_b.data, e_b.due);
        end
        last_b = e_b.data;
      end
    end else if (rd_data_b !== last_b) begin
      errors++;
      $display("FAIL b_hold got %h required %h", rd_data_b, last_b);
    end
  end

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    wr_en_a = '0; rd_en_a = 1'b0; init_start_a = 1'b0;
    wr_en_b = '0; rd_en_b = 1'b0; init_start_b = 1'b0;
  endtask

  // Call a_write before a_read in the same cycle so a collision expects forwarded lanes.
  task automatic a_write(input logic [5:0] addr, input logic [3:0] strb, input logic [31:0] data);
    logic [31:0] m;
    m = strb_mask(strb);
    wr_en_a = strb; wr_addr_a = addr; wr_data_a = data;
    model_a[addr] = (model_a[addr] & ~m) | (data & m);
  endtask

  task automatic a_read(input logic [5:0] addr);
    exp_t e;
    rd_en_a = 1'b1; rd_addr_a = addr;
    e.data = model_a[addr]; e.due = cyc_n + 1;
    q_a.push_back(e);
  endtask

  task automatic b_write(input logic [5:0] addr, input logic [31:0] data);
    wr_en_b = 1'b1; wr_addr_b = addr; wr_data_b = data;
    if (addr < 6'd48) model_b[addr] = data;
  endtask

  task automatic b_read(input logic [5:0] addr);
    exp_t e;
    rd_en_b = 1'b1; rd_addr_b = addr;
    e.data = (addr < 6'd48) ? model_b[addr] : 32'h0;
    e.due  = cyc_n + 2;
    q_b.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 20) begin
      step();
      n++;
    end
    step();
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending a=%0d b=%0d required 0", q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
  endtask

  task automatic test_reset();
    int n = 0, na = -1, nb = -1;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) step();
    checks++;
    if (init_done_a !== 1'b0 || init_done_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_init_done got a=%b b=%b required 0 0", init_done_a, init_done_b);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    step();
    while ((na < 0 || nb < 0) && n < 200) begin
      step();
      n++;
      if (init_done_a === 1'b1 && na < 0) na = n;
      if (init_done_b === 1'b1 && nb < 0) nb = n;
    end
    checks++;
    if (na != 65) begin
      errors++;
      $display("FAIL a_init_time got %0d cycles required 65", na);
    end
    checks++;
    if (nb != 49) begin
      errors++;
      $display("FAIL b_init_time got %0d cycles required 49", nb);
    end
    for (int i = 0; i < 64; i++) model_a[i] = A_INIT;
    for (int i = 0; i < 48; i++) model_b[i] = B_INIT;
  endtask

  task automatic test_init_values();
    a_read(6'd0);  b_read(6'd0);  step();
    a_read(6'd31); b_read(6'd47); step();
    a_read(6'd63); step();
    drain();
  endtask

  task automatic test_rd_lat2();
    b_write(6'd5, 32'h0000_1234); step();
    b_read(6'd5); step();
    repeat (5) step();
    b_read(6'd6); step();
    drain();
  endtask

  task automatic test_bypass();
    a_write(6'd9, 4'hF, 32'h1122_3344); step();
    a_write(6'd9, 4'b0101, 32'hAABB_CCDD); a_read(6'd9); step();
    a_read(6'd9); step();
    a_write(6'd11, 4'hF, 32'hCAFE_F00D); a_read(6'd10); step();
    a_read(6'd11); step();
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      a_write(6'(20 + i), 4'($urandom_range(1, 15)), $urandom);
      if (i > 0) a_read(6'(19 + i));
      step();
    end
    for (int i = 0; i < 16; i++) begin
      a_read(6'(20 + i));
      step();
    end
    drain();
  endtask

  task automatic test_b_oor();
    b_write(6'd50, 32'hDEAD_BEEF); step();
    b_read(6'd50); step();
    for (int i = 0; i < 48; i++) begin
      b_read(6'(i));
      step();
    end
    drain();
  endtask

  task automatic test_init_block();
    int n, vld_before;
    a_write(6'd2, 4'hF, 32'h1234_5678); step();
    init_start_a = 1'b1; step();
    n = 0;
    checks++;
    if (init_done_a !== 1'b1) begin
      errors++;
      $display("FAIL reinit_done_hold got %b required 1", init_done_a);
    end
    step();
    n = 1;
    checks++;
    if (init_done_a !== 1'b0) begin
      errors++;
      $display("FAIL reinit_done_fall got %b required 0", init_done_a);
    end
    vld_before = vld_cnt_a;
    while (init_done_a !== 1'b1 && n < 200) begin
      if (n == 40 || n == 41) begin
        wr_en_a = 4'hF; wr_addr_a = 6'd2; wr_data_a = 32'h0BAD_0BAD;
        rd_en_a = 1'b1; rd_addr_a = 6'd2;
      end
      step();
      n++;
    end
    checks++;
    if (n != 65) begin
      errors++;
      $display("FAIL reinit_time got %0d cycles required 65", n);
    end
    checks++;
    if (vld_cnt_a != vld_before) begin
      errors++;
      $display("FAIL init_rd_vld got %0d pulses required 0", vld_cnt_a - vld_before);
    end
    for (int i = 0; i < 64; i++) model_a[i] = A_INIT;
    for (int i = 0; i < 64; i++) begin
      a_read(6'(i));
      step();
    end
    drain();
  endtask

  task automatic test_mid_init_reset();
    int n = 0;
    a_write(6'd40, 4'hF, 32'h0BAD_CAFE); step();
    init_start_a = 1'b1; step();
    repeat (31) step();
    rst_a = 1'b1;
    step(); step();
    checks++;
    if (init_done_a !== 1'b0) begin
      errors++;
      $display("FAIL midinit_rst_done got %b required 0", init_done_a);
    end
    rst_a = 1'b0;
    step();
    while (init_done_a !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n != 65) begin
      errors++;
      $display("FAIL midinit_restart_time got %0d cycles required 65", n);
    end
    for (int i = 0; i < 64; i++) model_a[i] = A_INIT;
    for (int i = 0; i < 64; i++) begin
      a_read(6'(i));
      step();
    end
    drain();
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    init_start_a = 1'b0; wr_en_a = '0; wr_addr_a = '0; wr_data_a = '0; rd_en_a = 1'b0; rd_addr_a = '0;
    init_start_b = 1'b0; wr_en_b = '0; wr_addr_b = '0; wr_data_b = '0; rd_en_b = 1'b0; rd_addr_b = '0;
    test_reset();
    test_init_values();
    test_rd_lat2();
    test_bypass();
    test_back_to_back();
    test_b_oor();
    test_init_block();
    test_mid_init_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
